// File: rtl/duram_rd_ctrl.sv
// Read-side controller for a single-clock FIFO on a dual-port RAM with 2-cycle
// registered read latency. It issues RAM reads while the FIFO holds data and
// downstream room exists. It tracks reads in flight, absorbs returning words
// in a small skid buffer, and presents a valid/ready stream.
//
// Ports:
//   Clk        system clock (shared with write side and RAM)
//   Reset      asynchronous active-high reset
//   wr_ptr     write pointer from write side (binary, with wrap bit)
//   flush      synchronous discard of all unread data
//   rd_addr    RAM port B address
//   ram_q      RAM port B read data
//   rd_ptr     read pointer returned to write side
//   out_data   stream data (skid head)
//   out_valid  stream valid
//   out_ready  stream ready from consumer
//   rd_used    words in RAM not yet issued (registered)
module duram_rd_ctrl #(
  parameter int unsigned DATA_WIDTH = 36,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   rd_used
);

  // One skid slot per read in flight plus one for the word being popped.
  localparam int unsigned SkidDepth = RD_LATENCY + 1;
  localparam logic [1:0]  LastIdx   = 2'(SkidDepth - 1);

  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   rd_used_q, rd_used_d;
  logic [1:0]            vld_q, vld_d;
  logic [1:0]            head_q, head_d;
  logic [1:0]            tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] skid_q [SkidDepth];

  logic       empty;
  logic       pop;
  logic       issue;
  logic       capture;
  logic [2:0] load;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == LastIdx) ? 2'd0 : idx + 2'd1;
  endfunction

  always_comb begin
    empty   = (rd_ptr_q == wr_ptr);
    pop     = out_valid & out_ready;
    // Words that will occupy the skid once all in-flight reads land, after this pop.
    load    = {1'b0, occ_q} + {2'b0, vld_q[0]} + {2'b0, vld_q[1]} - {2'b0, pop};
    issue   = !empty && !flush && (load <= 3'd2);
    // Data returning during a flush belongs to discarded entries.
    capture = vld_q[1] && !flush;

    rd_ptr_d = rd_ptr_q;
    vld_d    = {vld_q[0], issue};
    head_d   = head_q;
    tail_d   = tail_q;
    occ_d    = occ_q;

    if (flush) begin
      rd_ptr_d = wr_ptr;
      vld_d    = 2'b00;
      head_d   = 2'd0;
      tail_d   = 2'd0;
      occ_d    = 2'd0;
    end else begin
      if (issue) begin
        rd_ptr_d = rd_ptr_q + (ADDR_WIDTH + 1)'(1);
      end
      if (capture) begin
        tail_d = next_idx(tail_q);
      end
      if (pop) begin
        head_d = next_idx(head_q);
      end
      occ_d = occ_q + {1'b0, capture} - {1'b0, pop};
    end

    rd_used_d = wr_ptr - rd_ptr_d;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_ptr_q  <= '0;
      rd_used_q <= '0;
      vld_q     <= 2'b00;
      head_q    <= 2'd0;
      tail_q    <= 2'd0;
      occ_q     <= 2'd0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      rd_used_q <= rd_used_d;
      vld_q     <= vld_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      occ_q     <= occ_d;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < SkidDepth; i++) begin
        skid_q[i] <= '0;
      end
    end else if (capture) begin
      skid_q[tail_q] <= ram_q;
    end
  end

  assign rd_addr   = rd_ptr_q[ADDR_WIDTH-1:0];
  assign rd_ptr    = rd_ptr_q;
  assign rd_used   = rd_used_q;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = skid_q[head_q];

endmodule

// File: doc/duram_rd_ctrl.md
Name: duram_rd_ctrl

Overview:
- Read-side controller for a single-clock FIFO built on the team's dual-port RAM wrapper (2-cycle registered read latency, port enables tied high).
- Compares its read pointer against the write side's pointer and issues RAM reads.
- Tracks the two in-flight read cycles and absorbs returning data in a 3-entry skid buffer.
- Presents a valid/ready stream to the consumer (e.g. MAC TX path) at one word per cycle sustained.

Parameters:
- DATA_WIDTH, 36, RAM word width and output data width.
- ADDR_WIDTH, 9, RAM address width; pointers are ADDR_WIDTH+1 bits (extra wrap bit).
- RD_LATENCY, 2, RAM read latency in cycles; fixed at 2 (skid depth = RD_LATENCY+1 = 3).

Ports:
- Clk  in  1  system clock, shared with the write side and both RAM ports.
- Reset  in  1  asynchronous, active-high reset.
- wr_ptr  in  ADDR_WIDTH+1  write pointer from write side, binary, same clock domain.
- flush  in  1  synchronous discard of all unread data.
- rd_addr  out  ADDR_WIDTH  RAM port B address (= rd_ptr[ADDR_WIDTH-1:0]).
- ram_q  in  DATA_WIDTH  RAM port B read data.
- rd_ptr  out  ADDR_WIDTH+1  read pointer returned to the write side for full detection.
- out_data  out  DATA_WIDTH  stream data (skid head).
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from consumer.
- rd_used  out  ADDR_WIDTH+1  words in RAM not yet issued (wr_ptr - rd_ptr, modulo 2^(ADDR_WIDTH+1)).

Behaviour:
Reset:
- rd_ptr = 0, in-flight pipe = 00, skid occupancy = 0.
- out_valid = 0, out_data = 0, rd_used = 0.

Signals:
- empty = (rd_ptr == wr_ptr).
- pop = out_valid & out_ready.

Issue:
- issue = !empty & !flush & (occ + inflight - pop <= 2).
- occ is skid occupancy (0..3); inflight is the popcount of the 2-bit valid pipe.
- On issue, rd_ptr increments at the clock edge; wraps naturally through 2^(ADDR_WIDTH+1).
- rd_addr is combinational from rd_ptr.

In-flight pipe:
- vld[0] <= issue; vld[1] <= vld[0].
- When vld[1] is 1, ram_q holds the word addressed two edges earlier; it is written into the skid tail at that edge.

Skid buffer:
- 3-entry circular buffer with head/tail indices.
- out_valid = (occ != 0); out_data = entry[head].
- Capture and pop in the same cycle: occ unchanged, both indices advance.
- The issue rule guarantees occ never exceeds 3. Overflow is a design error; the bench asserts on it.

Latency:
- First word written (wr_ptr change visible in cycle t) -> issue in t -> out_valid high in t+3.
- Steady state with out_ready held high: one word per cycle, no bubbles.

Backpressure:
- out_ready low: at most 3 words are outstanding (occ + inflight <= 3); issue stops until pops resume.
- out_data and out_valid hold stable while out_valid=1 & out_ready=0.

flush (single cycle):
- rd_ptr <= wr_ptr (sampled that cycle), vld <= 00, occ <= 0, head = tail = 0.
- out_valid is 0 the next cycle.
- No issue occurs in the flush cycle; data already returning from the RAM is dropped.
- A write landing in the flush cycle is discarded with the rest.

rd_used:
- Registered, updated each cycle from next-state pointers.
- Values range 0..2^ADDR_WIDTH; full RAM = 2^ADDR_WIDTH.

Reset mid-operation: all state returns to reset values immediately (asynchronous); in-flight RAM data is ignored.

Test Plan:
- Write 1 word (0x123456789) at cycle 10, out_ready=1 -> rd_addr=0 issued cycle 10, out_valid=1 with out_data=0x123456789 in cycle 13 for exactly 1 cycle, rd_ptr=1, rd_used=0.
- Burst of 8 words (0..7), out_ready=1 -> 8 consecutive out_valid cycles carrying 0..7 in order, no gaps, rd_ptr=8.
- 8 words, out_ready=0 for 20 cycles, then 1 -> rd_ptr stops at 3, rd_used=5, out_data=0 held stable; after release, 0..7 delivered in order with no loss or duplication.
- Wrap: pre-advance both pointers to 510, write 4 words -> rd_addr sequence 510, 511, 0, 1; rd_ptr goes 0x1FF -> 0x200 -> 0x201 -> 0x202 (wrap bit set).
- flush with 2 words in skid, 1 in flight, 5 unissued -> next cycle out_valid=0, rd_ptr=wr_ptr, rd_used=0; the word returning from the RAM afterwards is not presented.
- Reset asserted during a streaming burst -> out_valid, rd_ptr and rd_used are 0 immediately; after release with wr_ptr=0, no spurious output.
